// File: rtl/fft_8_pkg.sv
// rtl/fft_8_pkg.sv - shared point count, sample width, FSM encoding and Q7 twiddle tables
package fft_8_pkg;

    localparam int FFT8_POINTS   = 8;
    localparam int FFT8_SAMPLE_W = 8;
    localparam int FFT8_TW_FRAC  = 7;

    typedef enum logic [1:0] {
        ST_LOAD    = 2'd0,
        ST_COMPUTE = 2'd1,
        ST_UNLOAD  = 2'd2
    } fft8_state_t;

    // cos(2*pi*m/8) in Q7, rounded to nearest
    function automatic logic signed [FFT8_TW_FRAC+1:0] tw_cos(input int m);
        logic [2:0] ph;
        ph = 3'(m);
        case (ph)
            3'd0:       tw_cos = 9'sd128;
            3'd1, 3'd7: tw_cos = 9'sd91;
            3'd2, 3'd6: tw_cos = 9'sd0;
            3'd3, 3'd5: tw_cos = -9'sd91;
            default:    tw_cos = -9'sd128;
        endcase
    endfunction

    function automatic logic signed [FFT8_TW_FRAC+1:0] tw_sin(input int m);
        logic [2:0] ph;
        ph = 3'(m);
        case (ph)
            3'd0, 3'd4: tw_sin = 9'sd0;
            3'd1, 3'd3: tw_sin = 9'sd91;
            3'd2:       tw_sin = 9'sd128;
            3'd5, 3'd7: tw_sin = -9'sd91;
            default:    tw_sin = -9'sd128;
        endcase
    endfunction

endpackage

// File: rtl/fft_8.sv
// rtl/fft_8.sv - combinational 8-point DFT core, Q7 twiddles, output scaled by 1/8 (floor), wraps at W bits
module fft_8
    import fft_8_pkg::*;
#(
    parameter int W = FFT8_SAMPLE_W
) (
    input  logic [FFT8_POINTS-1:0][W-1:0] x_real,
    input  logic [FFT8_POINTS-1:0][W-1:0] x_image,
    output logic [FFT8_POINTS-1:0][W-1:0] y_real,
    output logic [FFT8_POINTS-1:0][W-1:0] y_image
);

    localparam int ACC_W    = W + FFT8_TW_FRAC + 6;
    localparam int TW_SHIFT = FFT8_TW_FRAC + 3;

    logic signed [ACC_W-1:0] acc_re;
    logic signed [ACC_W-1:0] acc_im;
    logic signed [ACC_W-1:0] xr;
    logic signed [ACC_W-1:0] xi;
    logic signed [ACC_W-1:0] c;
    logic signed [ACC_W-1:0] s;

    // Element k of the vectors is core input/output x(k+1)/y(k+1)
    always_comb begin
        y_real  = '0;
        y_image = '0;
        acc_re  = '0;
        acc_im  = '0;
        xr      = '0;
        xi      = '0;
        c       = '0;
        s       = '0;
        for (int k = 0; k < FFT8_POINTS; k++) begin
            acc_re = '0;
            acc_im = '0;
            for (int n = 0; n < FFT8_POINTS; n++) begin
                xr     = ACC_W'($signed(x_real[n]));
                xi     = ACC_W'($signed(x_image[n]));
                c      = ACC_W'(tw_cos(n * k));
                s      = ACC_W'(tw_sin(n * k));
                acc_re = acc_re + xr * c + xi * s;
                acc_im = acc_im + xi * c - xr * s;
            end
            y_real[k]  = W'(acc_re >>> TW_SHIFT);
            y_image[k] = W'(acc_im >>> TW_SHIFT);
        end
    end

endmodule

// File: rtl/fft_8_stream_ctrl.sv
// rtl/fft_8_stream_ctrl.sv - streaming load/compute/unload wrapper around fft_8; FFT8_CORE_OUT_REG_EN adds a core output register
module fft_8_stream_ctrl
    import fft_8_pkg::*;
#(
    parameter int N = 3,
    parameter int W = FFT8_SAMPLE_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_real,
    input  logic [W-1:0] in_image,
    input  logic         in_last,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_real,
    output logic [W-1:0] out_image,
    output logic         out_last,
    output logic         frame_err
);

    localparam logic [N-1:0] LAST_IDX = N'(FFT8_POINTS - 1);

    fft8_state_t state, next_state;
    logic [N-1:0] idx;
    logic [N-1:0] odx;
    logic [N-1:0] show_slot;
    logic         in_fire;
    logic         out_fire;

    logic [FFT8_POINTS-1:0][W-1:0] in_re_buf;
    logic [FFT8_POINTS-1:0][W-1:0] in_im_buf;
    logic [FFT8_POINTS-1:0][W-1:0] out_re_buf;
    logic [FFT8_POINTS-1:0][W-1:0] out_im_buf;
    logic [FFT8_POINTS-1:0][W-1:0] core_re;
    logic [FFT8_POINTS-1:0][W-1:0] core_im;

`ifdef FFT8_CORE_OUT_REG_EN
    logic [FFT8_POINTS-1:0][W-1:0] core_re_q;
    logic [FFT8_POINTS-1:0][W-1:0] core_im_q;
    logic                          core_phase;
`endif

    fft_8 #(
        .W (W)
    ) u_core (
        .x_real  (in_re_buf),
        .x_image (in_im_buf),
        .y_real  (core_re),
        .y_image (core_im)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_LOAD;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        in_ready   = (state == ST_LOAD);
        in_fire    = in_valid && in_ready;
        out_fire   = out_valid && out_ready;
        case (state)
            ST_LOAD: begin
                if (in_fire && idx == LAST_IDX) begin
                    next_state = ST_COMPUTE;
                end
            end
            ST_COMPUTE: begin
`ifdef FFT8_CORE_OUT_REG_EN
                if (core_phase) begin
                    next_state = ST_UNLOAD;
                end
`else
                next_state = ST_UNLOAD;
`endif
            end
            ST_UNLOAD: begin
                if (out_fire && odx == LAST_IDX) begin
                    next_state = ST_LOAD;
                end
            end
            default: next_state = ST_LOAD;
        endcase
    end

    // Slot to put on the output register: the current one on first entry, the next one after a transfer
    assign show_slot = out_valid ? odx + N'(1) : odx;

    always_ff @(posedge clk) begin
        if (rst) begin
            idx        <= '0;
            odx        <= '0;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            out_real   <= '0;
            out_image  <= '0;
            frame_err  <= 1'b0;
`ifdef FFT8_CORE_OUT_REG_EN
            core_phase <= 1'b0;
`endif
        end else begin
            frame_err <= in_fire && in_last && (idx != LAST_IDX);
            if (in_fire) begin
                idx <= (in_last || idx == LAST_IDX) ? '0 : idx + N'(1);
            end
`ifdef FFT8_CORE_OUT_REG_EN
            core_phase <= (state == ST_COMPUTE) && !core_phase;
`endif
            if (state == ST_UNLOAD) begin
                if (out_fire && odx == LAST_IDX) begin
                    out_valid <= 1'b0;
                    out_last  <= 1'b0;
                    odx       <= '0;
                end else if (!out_valid || out_fire) begin
                    out_valid <= 1'b1;
                    out_real  <= out_re_buf[show_slot];
                    out_image <= out_im_buf[show_slot];
                    out_last  <= (show_slot == LAST_IDX);
                    odx       <= show_slot;
                end
            end
        end
    end

    // Data buffers carry no reset; the FSM never exposes stale contents
    always_ff @(posedge clk) begin
        if (in_fire) begin
            in_re_buf[idx] <= in_real;
            in_im_buf[idx] <= in_image;
        end
`ifdef FFT8_CORE_OUT_REG_EN
        if (state == ST_COMPUTE && !core_phase) begin
            core_re_q <= core_re;
            core_im_q <= core_im;
        end
        if (state == ST_COMPUTE && core_phase) begin
            out_re_buf <= core_re_q;
            out_im_buf <= core_im_q;
        end
`else
        if (state == ST_COMPUTE) begin
            out_re_buf <= core_re;
            out_im_buf <= core_im;
        end
`endif
    end

endmodule

// File: tb/tb_fft_8_stream_ctrl.sv
// tb/tb_fft_8_stream_ctrl.sv - randomized self-checking bench for fft_8_stream_ctrl against a trig-based DFT model
module tb_fft_8_stream_ctrl;

    localparam int W = 8;
`ifdef FFT8_CORE_OUT_REG_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_real;
    logic [W-1:0] in_image;
    logic         in_last;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_real;
    logic [W-1:0] out_image;
    logic         out_last;
    logic         frame_err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int ferr_cnt = 0;
    int fr[8];
    int fi[8];
    int er[8];
    int ei[8];

    fft_8_stream_ctrl #(.N(3), .W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_real   (in_real),
        .in_image  (in_image),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_real  (out_real),
        .out_image (out_image),
        .out_last  (out_last),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (frame_err) ferr_cnt <= ferr_cnt + 1;

    task automatic check_eq(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int q7(input real r);
        if (r >= 0.0) return $rtoi(r * 128.0 + 0.5);
        return -$rtoi(-r * 128.0 + 0.5);
    endfunction

    function automatic int sx(input int v);
        return (v >= 128) ? v - 256 : v;
    endfunction

    // X(k) = sum x(n) e^{-j 2 pi n k / 8}, twiddles in Q7, divided by 8 with floor, wrapped to 8 bits
    task automatic model();
        int sr, si, c, s;
        real ang;
        for (int k = 0; k < 8; k++) begin
            sr = 0;
            si = 0;
            for (int n = 0; n < 8; n++) begin
                ang = 2.0 * 3.14159265358979 * n * k / 8.0;
                c = q7($cos(ang));
                s = q7($sin(ang));
                sr += sx(fr[n]) * c + sx(fi[n]) * s;
                si += sx(fi[n]) * c - sx(fr[n]) * s;
            end
            er[k] = (sr >>> 10) & 255;
            ei[k] = (si >>> 10) & 255;
        end
    endtask

    task automatic send_frame(input int nsamp, input bit gaps, input bit last_flag, output int c_acc);
        int t;
        for (int i = 0; i < nsamp; i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    in_valid = 1'b0;
                    @(posedge clk); #1;
                end
            end
            in_valid = 1'b1;
            in_real  = W'(fr[i]);
            in_image = W'(fi[i]);
            in_last  = last_flag && (i == nsamp - 1);
            t = 0;
            while (!in_ready && t < 100) begin
                @(posedge clk); #1;
                t++;
            end
            if (!in_ready) check_eq("in_ready_timeout", 0, 1);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        c_acc    = cyc;
    endtask

    task automatic recv_frame(input int c0, input int mode, input int nres);
        int got, t, pat, hr, hi, hl;
        bit first, stalled;
        got = 0; t = 0; pat = 0; first = 1; stalled = 0;
        hr = 0; hi = 0; hl = 0;
        while (got < nres && t < 300) begin
            out_ready = (mode == 0) ? 1'b1 : ((pat % 4 == 0) || (pat % 4 == 3));
            pat++;
            if (mode != 0) begin
                in_valid = 1'($urandom);
                in_real  = W'($urandom);
                in_last  = 1'($urandom);
            end
            if (stalled && !out_valid) check_eq("valid_dropped_in_stall", 0, 1);
            if (out_valid) begin
                if (first) check_eq("latency", cyc - c0, LAT);
                first = 0;
                check_eq("in_ready_busy", in_ready, 0);
                if (stalled) begin
                    check_eq("held_re", out_real, hr);
                    check_eq("held_im", out_image, hi);
                    check_eq("held_last", out_last, hl);
                end
                if (out_ready) begin
                    check_eq($sformatf("bin%0d_re", got), out_real, er[got]);
                    check_eq($sformatf("bin%0d_im", got), out_image, ei[got]);
                    check_eq($sformatf("bin%0d_last", got), out_last, got == 7);
                    got++;
                    stalled = 0;
                end else begin
                    stalled = 1;
                    hr = out_real; hi = out_image; hl = out_last;
                end
            end
            @(posedge clk); #1;
            t++;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (got < nres) check_eq("recv_timeout", got, nres);
        if (nres == 8) begin
            check_eq("idle_out_valid", out_valid, 0);
            check_eq("idle_in_ready", in_ready, 1);
        end
    endtask

    task automatic rand_frame();
        for (int i = 0; i < 8; i++) begin
            fr[i] = $urandom_range(0, 255);
            fi[i] = $urandom_range(0, 255);
        end
        model();
    endtask

    initial begin
        int c0, fe0;
        int vec[8];
        vec = '{8'h39, 8'h57, 8'h57, 8'h39, 8'h39, 8'h57, 8'h57, 8'h39};
        rst = 1'b1; in_valid = 1'b0; in_real = '0; in_image = '0; in_last = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_in_ready", in_ready, 1);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_out_last", out_last, 0);
        check_eq("rst_frame_err", frame_err, 0);
        check_eq("rst_out_real", out_real, 0);
        check_eq("rst_out_image", out_image, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // directed vector, consumer always ready
        for (int i = 0; i < 8; i++) begin fr[i] = vec[i]; fi[i] = 0; end
        model();
        send_frame(8, 0, 1, c0);
        recv_frame(c0, 0, 8);

        // all-zero frame
        fe0 = ferr_cnt;
        for (int i = 0; i < 8; i++) begin fr[i] = 0; fi[i] = 0; end
        model();
        send_frame(8, 1, 1, c0);
        recv_frame(c0, 0, 8);
        check_eq("zero_frame_err", ferr_cnt - fe0, 0);

        // short frame closed on the 3rd sample
        fe0 = ferr_cnt;
        rand_frame();
        send_frame(3, 0, 1, c0);
        check_eq("short_frame_err_pulse", frame_err, 1);
        repeat (4) begin
            @(posedge clk); #1;
            check_eq("short_no_output", out_valid, 0);
            check_eq("short_in_ready", in_ready, 1);
        end
        check_eq("short_err_count", ferr_cnt - fe0, 1);
        rand_frame();
        send_frame(8, 1, 1, c0);
        recv_frame(c0, 0, 8);

        // random frames, stalled consumer, idle in_valid noise during unload
        for (int f = 0; f < 4; f++) begin
            rand_frame();
            send_frame(8, 1, f != 2, c0);
            recv_frame(c0, 1, 8);
        end

        // reset while presenting bin 4
        rand_frame();
        send_frame(8, 0, 1, c0);
        recv_frame(c0, 0, 4);
        check_eq("pre_rst_valid", out_valid, 1);
        out_ready = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_eq("mid_rst_out_valid", out_valid, 0);
        check_eq("mid_rst_in_ready", in_ready, 1);
        check_eq("mid_rst_out_last", out_last, 0);
        rand_frame();
        send_frame(8, 1, 1, c0);
        recv_frame(c0, 0, 8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
